// File: rtl/wb_regfile_writeback_pkg.sv
// Shared constants for the decode and write-back ends of the register-file path.
// Covers the SP adjust encodings, register-file defaults and decode operand/branch selectors.
package wb_regfile_writeback_pkg;

  localparam int          DATA_W_DEF   = 8;
  localparam int          ADDR_W_DEF   = 2;
  localparam int          SP_IDX_DEF   = 3;
  localparam logic [7:0]  SP_RESET_DEF = 8'hFF;

  typedef enum logic [1:0] {
    SP_OP_NONE = 2'b00,
    SP_OP_DEC  = 2'b01,
    SP_OP_INC  = 2'b10,
    SP_OP_RSVD = 2'b11
  } sp_op_e;

  // Decode-side source selects (SD1/SD2/SD3 mux steering) and opcodes that touch the stack.
  typedef enum logic [1:0] {
    SD_REG  = 2'b00,
    SD_SP   = 2'b01,
    SD_IMM  = 2'b10,
    SD_PC   = 2'b11
  } sd_sel_e;

  localparam logic [3:0] OPC_PUSH = 4'h8;
  localparam logic [3:0] OPC_POP  = 4'h9;
  localparam logic [3:0] OPC_CALL = 4'hA;
  localparam logic [3:0] OPC_RET  = 4'hB;
  localparam logic [3:0] OPC_RTI  = 4'hC;

  localparam logic [1:0] BRX_NONE = 2'b00;
  localparam logic [1:0] BRX_JMP  = 2'b01;
  localparam logic [1:0] BRX_CALL = 2'b10;
  localparam logic [1:0] BRX_RET  = 2'b11;

  // Reserved encoding behaves as "no adjust".
  function automatic logic sp_op_active(input logic [1:0] op);
    return (op == SP_OP_DEC) || (op == SP_OP_INC);
  endfunction

endpackage

// File: rtl/wb_regfile_writeback_regfile_array.sv
// Register storage: NREG x DATA_W, two combinational read ports, a data write port
// and a dedicated SP update port; a data write to SP overrides the SP update.
module regfile_array
  import wb_regfile_writeback_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sp_en,
  input  logic [DATA_W-1:0] sp_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_value
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_hits_sp;

  assign wr_hits_sp = wr_en && (wr_addr == ADDR_W'(SP_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      if (sp_en && !wr_hits_sp) begin
        regs[SP_IDX] <= sp_data;
      end
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign sp_value  = regs[SP_IDX];

endmodule

// File: rtl/wb_regfile_writeback.sv
// Write-back stage: captures the WB request, commits it one cycle later into the
// register file with write-through bypass on the read ports, and tracks stack wrap.
module wb_regfile_writeback
  import wb_regfile_writeback_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        wb_sp_op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              sp_ovf_clr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_ovf,
  output logic              sp_unf,
  output logic              sp_conflict
);

  logic              cap_valid;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_rd;
  logic [DATA_W-1:0] cap_data;
  logic [1:0]        cap_sp_op;

  logic              commit;
  logic              data_we;
  logic              sp_req;
  logic              conflict;
  logic              sp_en;
  logic [DATA_W-1:0] sp_cur;
  logic [DATA_W-1:0] sp_next;
  logic              wrap_ovf;
  logic              wrap_unf;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;

  // Flush beats stall; a stalled entry holds its fields unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_we    <= 1'b0;
      cap_rd    <= '0;
      cap_data  <= '0;
      cap_sp_op <= SP_OP_NONE;
    end else if (wb_flush) begin
      cap_valid <= 1'b0;
    end else if (!wb_stall) begin
      cap_valid <= wb_valid;
      cap_we    <= wb_we;
      cap_rd    <= wb_rd;
      cap_data  <= wb_data;
      cap_sp_op <= wb_sp_op;
    end
  end

  always_comb begin
    commit   = cap_valid && !wb_stall && !wb_flush;
    data_we  = commit && cap_we;
    sp_req   = commit && sp_op_active(cap_sp_op);
    conflict = data_we && sp_req && (cap_rd == ADDR_W'(SP_IDX));
    sp_en    = sp_req && !conflict;
    sp_next  = (cap_sp_op == SP_OP_DEC) ? (sp_cur - DATA_W'(1)) : (sp_cur + DATA_W'(1));
    wrap_ovf = sp_en && (cap_sp_op == SP_OP_DEC) && (sp_cur == '0);
    wrap_unf = sp_en && (cap_sp_op == SP_OP_INC) && (sp_cur == '1);
  end

  regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SP_IDX   (SP_IDX),
    .SP_RESET (SP_RESET)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (data_we),
    .wr_addr   (cap_rd),
    .wr_data   (cap_data),
    .sp_en     (sp_en),
    .sp_data   (sp_next),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (arr_a),
    .rd_data_b (arr_b),
    .sp_value  (sp_cur)
  );

  // Write-through: a commit this cycle is visible to decode before the edge.
  always_comb begin
    rd_data_a = arr_a;
    rd_data_b = arr_b;
    if (data_we && (cap_rd == rd_addr_a)) begin
      rd_data_a = cap_data;
    end else if (sp_en && (rd_addr_a == ADDR_W'(SP_IDX))) begin
      rd_data_a = sp_next;
    end
    if (data_we && (cap_rd == rd_addr_b)) begin
      rd_data_b = cap_data;
    end else if (sp_en && (rd_addr_b == ADDR_W'(SP_IDX))) begin
      rd_data_b = sp_next;
    end
  end

  assign sp_out = sp_cur;

  // Set wins over clear for the sticky wrap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_ovf      <= 1'b0;
      sp_unf      <= 1'b0;
      sp_conflict <= 1'b0;
    end else begin
      sp_conflict <= conflict;
      if (wrap_ovf) begin
        sp_ovf <= 1'b1;
      end else if (sp_ovf_clr) begin
        sp_ovf <= 1'b0;
      end
      if (wrap_unf) begin
        sp_unf <= 1'b1;
      end else if (sp_ovf_clr) begin
        sp_unf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Directed bench for wb_regfile_writeback: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_valid, wb_stall, wb_flush, wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic [1:0] wb_sp_op;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic       sp_ovf_clr;
  logic [7:0] rd_data_a, rd_data_b, sp_out;
  logic       sp_ovf, sp_unf, sp_conflict;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sp;
    logic       ovf;
    logic       unf;
    logic       conf;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  wb_regfile_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_stall    (wb_stall),
    .wb_flush    (wb_flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_sp_op    (wb_sp_op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .sp_ovf_clr  (sp_ovf_clr),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .sp_out      (sp_out),
    .sp_ovf      (sp_ovf),
    .sp_unf      (sp_unf),
    .sp_conflict (sp_conflict)
  );

  task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got %02h, expected %02h", name, field, act, exp);
    end
  endtask

  // Monitor: whenever the stimulus side flags a sample point, pop and compare.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "rd_data_a", rd_data_a, e.a);
        cmp(e.name, "rd_data_b", rd_data_b, e.b);
        cmp(e.name, "sp_out", sp_out, e.sp);
        cmp(e.name, "sp_ovf", {7'b0, sp_ovf}, {7'b0, e.ovf});
        cmp(e.name, "sp_unf", {7'b0, sp_unf}, {7'b0, e.unf});
        cmp(e.name, "sp_conflict", {7'b0, sp_conflict}, {7'b0, e.conf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic apply_stimulus(input logic v, input logic we, input logic [1:0] rd,
                                input logic [7:0] data, input logic [1:0] op,
                                input logic stall, input logic flush);
    wb_valid = v;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = data;
    wb_sp_op = op;
    wb_stall = stall;
    wb_flush = flush;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [1:0] ra, input logic [1:0] rb,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] sp,
                              input logic ovf, input logic unf, input logic conf);
    exp_t e;
    rd_addr_a = ra;
    rd_addr_b = rb;
    e.name = name; e.a = a; e.b = b; e.sp = sp; e.ovf = ovf; e.unf = unf; e.conf = conf;
    exp_q.push_back(e);
    chk_req = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    sp_ovf_clr = 1'b0;
    rd_addr_a = 2'd0;
    rd_addr_b = 2'd0;
    idle();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_output("rst_sp", 2'd3, 2'd0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0); tick();
    check_output("rst_r12", 2'd1, 2'd2, 8'h00, 8'h00, 8'hFF, 0, 0, 0); tick();

    // Plain write R1=5A: capture, bypass during commit cycle, then array
    apply_stimulus(1, 1, 2'd1, 8'h5A, 2'b00, 0, 0);
    check_output("wr_pre", 2'd1, 2'd0, 8'h00, 8'h00, 8'hFF, 0, 0, 0); tick();
    idle();
    check_output("wr_byp", 2'd1, 2'd1, 8'h5A, 8'h5A, 8'hFF, 0, 0, 0); tick();
    check_output("wr_arr", 2'd1, 2'd2, 8'h5A, 8'h00, 8'hFF, 0, 0, 0); tick();

    // SP FF->FE, then POP: R2=C3 and SP FE->FF in one commit
    apply_stimulus(1, 0, 2'd0, 8'h00, 2'b01, 0, 0); tick();
    idle();
    check_output("dec_byp", 2'd3, 2'd0, 8'hFE, 8'h00, 8'hFF, 0, 0, 0); tick();
    apply_stimulus(1, 1, 2'd2, 8'hC3, 2'b10, 0, 0); tick();
    idle();
    check_output("pop_byp", 2'd2, 2'd3, 8'hC3, 8'hFF, 8'hFE, 0, 0, 0); tick();
    check_output("pop_arr", 2'd2, 2'd3, 8'hC3, 8'hFF, 8'hFF, 0, 0, 0); tick();

    // Underflow: SP FF + 1 -> 00
    apply_stimulus(1, 0, 2'd0, 8'h00, 2'b10, 0, 0); tick();
    idle();
    check_output("unf_byp", 2'd3, 2'd0, 8'h00, 8'h00, 8'hFF, 0, 0, 0); tick();
    check_output("unf_set", 2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 0, 1, 0); tick();

    // Overflow: SP 00 - 1 -> FF, sticky, then cleared
    apply_stimulus(1, 0, 2'd0, 8'h00, 2'b01, 0, 0); tick();
    idle();
    check_output("ovf_byp", 2'd3, 2'd1, 8'hFF, 8'h5A, 8'h00, 0, 1, 0); tick();
    check_output("ovf_set", 2'd3, 2'd1, 8'hFF, 8'h5A, 8'hFF, 1, 1, 0); tick();
    check_output("ovf_hold", 2'd3, 2'd1, 8'hFF, 8'h5A, 8'hFF, 1, 1, 0); tick();
    sp_ovf_clr = 1'b1; tick();
    sp_ovf_clr = 1'b0;
    check_output("flag_clr", 2'd3, 2'd0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0); tick();

    // Wrap coinciding with clear: set wins
    apply_stimulus(1, 0, 2'd0, 8'h00, 2'b10, 0, 0); tick();
    idle();
    sp_ovf_clr = 1'b1; tick();
    sp_ovf_clr = 1'b0;
    check_output("set_wins", 2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 0, 1, 0); tick();

    // Conflict: data write to SP beats the SP-1 (which would have wrapped)
    apply_stimulus(1, 1, 2'd3, 8'h80, 2'b01, 0, 0); tick();
    idle();
    check_output("conf_byp", 2'd3, 2'd3, 8'h80, 8'h80, 8'h00, 0, 1, 0); tick();
    check_output("conf_pulse", 2'd3, 2'd0, 8'h80, 8'h00, 8'h80, 0, 1, 1); tick();
    check_output("conf_end", 2'd3, 2'd0, 8'h80, 8'h00, 8'h80, 0, 1, 0); tick();

    // Stall 3 cycles with flush in the 2nd: R0 never written
    apply_stimulus(1, 1, 2'd0, 8'h11, 2'b00, 0, 0); tick();
    apply_stimulus(0, 0, 2'd0, 8'h00, 2'b00, 1, 0);
    check_output("stall1", 2'd0, 2'd1, 8'h00, 8'h5A, 8'h80, 0, 1, 0); tick();
    apply_stimulus(0, 0, 2'd0, 8'h00, 2'b00, 1, 1);
    check_output("stall2_flush", 2'd0, 2'd1, 8'h00, 8'h5A, 8'h80, 0, 1, 0); tick();
    apply_stimulus(0, 0, 2'd0, 8'h00, 2'b00, 1, 0);
    check_output("stall3", 2'd0, 2'd1, 8'h00, 8'h5A, 8'h80, 0, 1, 0); tick();
    idle();
    check_output("flush_rel", 2'd0, 2'd0, 8'h00, 8'h00, 8'h80, 0, 1, 0); tick();
    check_output("flush_after", 2'd0, 2'd0, 8'h00, 8'h00, 8'h80, 0, 1, 0); tick();

    // Stall without flush: entry held, commits on release
    apply_stimulus(1, 1, 2'd2, 8'h33, 2'b00, 0, 0); tick();
    apply_stimulus(0, 0, 2'd0, 8'h00, 2'b00, 1, 0);
    check_output("hold1", 2'd2, 2'd0, 8'hC3, 8'h00, 8'h80, 0, 1, 0); tick();
    check_output("hold2", 2'd2, 2'd0, 8'hC3, 8'h00, 8'h80, 0, 1, 0); tick();
    idle();
    check_output("hold_rel", 2'd2, 2'd2, 8'h33, 8'h33, 8'h80, 0, 1, 0); tick();
    check_output("hold_arr", 2'd2, 2'd0, 8'h33, 8'h00, 8'h80, 0, 1, 0); tick();

    // Reset mid-stall discards the captured entry
    apply_stimulus(1, 1, 2'd0, 8'h44, 2'b00, 0, 0); tick();
    apply_stimulus(0, 0, 2'd0, 8'h00, 2'b00, 1, 0); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    idle();
    check_output("rst_mid", 2'd0, 2'd3, 8'h00, 8'hFF, 8'hFF, 0, 0, 0); tick();
    check_output("rst_after", 2'd0, 2'd2, 8'h00, 8'h00, 8'hFF, 0, 0, 0); tick();

    tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
    end
  end

endmodule
